// File: rtl/dct_pkg.sv
// Shared constants, rounding helper and vector type for the fixed-point lifting DCT/IDCT pair.
package dct_pkg;

  localparam int FRAC_BITS      = 3;
  localparam int IDCT_OUT_SHIFT = 5;
  localparam int IDCT_LAT       = 8;
  localparam int DCT_IW         = 24;

  typedef logic signed [DCT_IW-1:0] dct_vec_t [8];

  // Round to a multiple of 2^FRAC_BITS, ties away from zero: a negative value
  // only carries when its low three bits are 5..7, a positive one when they are 4..7.
  function automatic logic signed [31:0] R(input logic signed [31:0] v);
    logic signed [31:0] bias;
    bias = v[31] ? 32'sd3 : 32'sd4;
    return ((v + bias) >>> FRAC_BITS) <<< FRAC_BITS;
  endfunction

endpackage

// File: rtl/idct_valid_pipe.sv
// Valid-bit shift register tracking which IDCT pipeline stages hold a live vector.
module idct_valid_pipe
  import dct_pkg::*;
#(
  parameter int DEPTH = IDCT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] valid_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
    end else if (advance) begin
      valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
    end
  end

  assign out_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/idct_ft_math.sv
// Pipelined 8-point 1-D inverse lifting DCT: undoes the forward lifting chain, then
// rounds by 1/32 and clamps to unsigned W-bit pixels with per-sample clip flags.
module idct_ft_math
  import dct_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = DCT_IW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0][15:0]     y_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0][W-1:0]    x_out,
  output logic [7:0]           out_clip
);

  typedef logic signed [IW-1:0] lane_t;
  localparam lane_t PIX_MAX = lane_t'((1 << W) - 1);

  logic  advance;
  logic  q_valid;
  lane_t s0 [8], s1 [8], s2 [8], s3 [8], s4 [8], s5 [8], s6 [8], sq [8];
  lane_t n1 [8], n2 [8], n3 [8], n4 [8], n5 [8], n6 [8], nq [8];
  logic [7:0][W-1:0] x_next;
  logic [7:0]        clip_next;

  function automatic lane_t rr(input lane_t v);
    return lane_t'(R(32'(v)));
  endfunction

  function automatic lane_t f38(input lane_t v);
    return (v >>> 3) + (v >>> 2);
  endfunction

  function automatic lane_t f58(input lane_t v);
    return (v >>> 1) + (v >>> 3);
  endfunction

  function automatic lane_t f78(input lane_t v);
    return (v >>> 1) + (v >>> 2) + (v >>> 3);
  endfunction

  function automatic lane_t rq(input lane_t p);
    lane_t half;
    half = lane_t'(1 << (IDCT_OUT_SHIFT - 1));
    return (p + (p[IW-1] ? half - lane_t'(1) : half)) >>> IDCT_OUT_SHIFT;
  endfunction

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  idct_valid_pipe #(.DEPTH(IDCT_LAT)) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .in_valid (in_valid),
    .out_valid(q_valid)
  );

  // Lifting steps run in the reverse order of the forward transform.
  always_comb begin
    n1 = s0;
    n1[1] = rr(s0[0] >>> 1) - s0[1];
    n1[3] = s0[3] - rr(f38(s0[2]));
    n1[4] = s0[4] + rr(s0[7] >>> 3);
    n1[6] = s0[6] + rr(s0[5] >>> 1);

    n2 = s1;
    n2[0] = s1[0] - s1[1];
    n2[2] = s1[2] + rr(f38(s1[3]));
    n2[5] = s1[5] - rr(f78(s1[6]));

    n3[0] = s2[0] + s2[3];
    n3[3] = s2[0] - s2[3];
    n3[1] = s2[1] + s2[2];
    n3[2] = s2[1] - s2[2];
    n3[4] = s2[4] + s2[5];
    n3[5] = s2[4] - s2[5];
    n3[7] = s2[7] + s2[6];
    n3[6] = s2[7] - s2[6];

    n4 = s3;
    n4[5] = rr(f58(s3[6])) - s3[5];

    n5 = s4;
    n5[6] = s4[6] - rr(f38(s4[5]));

    for (int i = 0; i < 4; i++) begin
      n6[i]     = s5[i] + s5[7-i];
      n6[7-i]   = s5[i] - s5[7-i];
    end

    for (int i = 0; i < 8; i++) begin
      nq[i] = rq(s6[i]);
    end
  end

  always_comb begin
    x_next    = '0;
    clip_next = '0;
    for (int i = 0; i < 8; i++) begin
      if (sq[i] < 0) begin
        clip_next[i] = 1'b1;
      end else if (sq[i] > PIX_MAX) begin
        x_next[i]    = PIX_MAX[W-1:0];
        clip_next[i] = 1'b1;
      end else begin
        x_next[i]    = sq[i][W-1:0];
      end
    end
  end

  // One global enable: every stage either advances together or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        s0[i] <= '0;
        s1[i] <= '0;
        s2[i] <= '0;
        s3[i] <= '0;
        s4[i] <= '0;
        s5[i] <= '0;
        s6[i] <= '0;
        sq[i] <= '0;
      end
      out_valid <= 1'b0;
      x_out     <= '0;
      out_clip  <= '0;
    end else if (advance) begin
      for (int i = 0; i < 8; i++) begin
        s0[i] <= lane_t'($signed(y_in[i])) <<< FRAC_BITS;
      end
      s1        <= n1;
      s2        <= n2;
      s3        <= n3;
      s4        <= n4;
      s5        <= n5;
      s6        <= n6;
      sq        <= nq;
      out_valid <= q_valid;
      x_out     <= x_next;
      out_clip  <= clip_next;
    end
  end

endmodule

// File: tb/tb_idct_ft_math.sv
// Self-checking bench for idct_ft_math: arithmetic model with scoreboard plus directed literal cases.
module tb_idct_ft_math;
  import dct_pkg::*;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0][15:0]  y_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0][W-1:0] x_out;
  logic [7:0]        out_clip;

  typedef struct {
    logic [7:0][W-1:0] x;
    logic [7:0]        clip;
    int                acc_cyc;
    int                acc_stalls;
  } exp_t;

  exp_t sb [$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   cyc         = 0;
  int   stalls      = 0;

  int                mon_y [8];
  logic [7:0][W-1:0] mon_x;
  logic [7:0]        mon_c;
  exp_t              mon_e;
  exp_t              cmp_e;

  idct_ft_math #(.W(W), .IW(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .out_clip (out_clip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, check_count=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int fl(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int rnd8(input int v);
    int m;
    m = (v < 0) ? -v : v;
    m = ((m + 4) / 8) * 8;
    return (v < 0) ? -m : m;
  endfunction

  // Straight integer evaluation of the inverse transform rules.
  function automatic void model(input int y [8], output logic [7:0][W-1:0] x, output logic [7:0] clip);
    int c [8];
    int a [8];
    int p [8];
    int m, q;
    for (int i = 0; i < 8; i++) c[i] = y[i] * 8;
    c[1] = rnd8(fl(c[0], 2)) - c[1];
    c[3] = c[3] - rnd8(fl(c[2], 8) + fl(c[2], 4));
    c[4] = c[4] + rnd8(fl(c[7], 8));
    c[6] = c[6] + rnd8(fl(c[5], 2));
    c[0] = c[0] - c[1];
    c[2] = c[2] + rnd8(fl(c[3], 8) + fl(c[3], 4));
    c[5] = c[5] - rnd8(fl(c[6], 2) + fl(c[6], 4) + fl(c[6], 8));
    a[0] = c[0] + c[3];  a[3] = c[0] - c[3];
    a[1] = c[1] + c[2];  a[2] = c[1] - c[2];
    a[4] = c[4] + c[5];  a[5] = c[4] - c[5];
    a[7] = c[7] + c[6];  a[6] = c[7] - c[6];
    a[5] = rnd8(fl(a[6], 2) + fl(a[6], 8)) - a[5];
    a[6] = a[6] - rnd8(fl(a[5], 8) + fl(a[5], 4));
    for (int i = 0; i < 4; i++) begin
      p[i]   = a[i] + a[7-i];
      p[7-i] = a[i] - a[7-i];
    end
    for (int i = 0; i < 8; i++) begin
      m = ((p[i] < 0 ? -p[i] : p[i]) + 16) / 32;
      q = (p[i] < 0) ? -m : m;
      if (q < 0) begin
        x[i] = '0;
        clip[i] = 1'b1;
      end else if (q > (1 << W) - 1) begin
        x[i] = W'((1 << W) - 1);
        clip[i] = 1'b1;
      end else begin
        x[i] = W'(q);
        clip[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [63:0] splat(input int k);
    return {8{8'(k)}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    check_count++;
    if (act === req) pass_count++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Called just after a falling edge; drives one cycle and returns at the next falling edge.
  task automatic applyStimulus(input bit v, input int yv [8], input bit ordy, output bit acc, output bit rdy);
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < 8; i++) y_in[i] = 16'(yv[i]);
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    @(negedge clk);
  endtask

  task automatic sendAndCheck(input string name, input int v [8], input logic [63:0] ex, input logic [7:0] ec);
    int  z [8];
    int  n;
    bit  acc, rdy;
    z = '{default: 0};
    applyStimulus(1'b1, v, 1'b1, acc, rdy);
    checkOutput({name, "_accept"}, 64'(acc), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      applyStimulus(1'b0, z, 1'b1, acc, rdy);
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(IDCT_LAT));
    checkOutput({name, "_x"}, x_out, ex);
    checkOutput({name, "_clip"}, 64'(out_clip), 64'(ec));
    applyStimulus(1'b0, z, 1'b1, acc, rdy);
  endtask

  // Scoreboard fill and stall accounting on the active edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b0) stalls++;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        for (int i = 0; i < 8; i++) mon_y[i] = int'($signed(y_in[i]));
        model(mon_y, mon_x, mon_c);
        mon_e.x          = mon_x;
        mon_e.clip       = mon_c;
        mon_e.acc_cyc    = cyc;
        mon_e.acc_stalls = stalls;
        sb.push_back(mon_e);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checkOutput("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        cmp_e = sb.pop_front();
        checkOutput("cmp_x", x_out, cmp_e.x);
        checkOutput("cmp_clip", 64'(out_clip), 64'(cmp_e.clip));
        checkOutput("cmp_latency", 64'(cyc - cmp_e.acc_cyc - (stalls - cmp_e.acc_stalls)), 64'(IDCT_LAT));
      end
    end
  end

  initial begin
    int  z [8];
    int  v [8];
    int  acv [4][8];
    logic [7:0][W-1:0] mx;
    logic [7:0] mc;
    logic [63:0] held;
    bit  acc, rdy, ordy;
    int  got, first, last, sent, bp_got, ghost;

    z = '{default: 0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; y_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_x", x_out, 64'd0);
    checkOutput("reset_clip", 64'(out_clip), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    v = '{800, 0, 0, 0, 0, 0, 0, 0};
    model(v, mx, mc);
    checkOutput("model_dc_x", mx, 64'h6464646464646464);
    checkOutput("model_dc_clip", 64'(mc), 64'd0);
    v = '{0, 80, 0, 0, 0, 0, 0, 0};
    model(v, mx, mc);
    checkOutput("model_ac_x", mx, 64'h1400001414000014);
    checkOutput("model_ac_clip", 64'(mc), 64'h66);

    v = '{800, 0, 0, 0, 0, 0, 0, 0};  sendAndCheck("dc", v, 64'h6464646464646464, 8'h00);
    v = '{-80, 0, 0, 0, 0, 0, 0, 0};  sendAndCheck("neg_clamp", v, 64'h0, 8'hFF);
    v = '{8000, 0, 0, 0, 0, 0, 0, 0}; sendAndCheck("overflow", v, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    sendAndCheck("zeros", z, 64'h0, 8'h00);
    v = '{0, 80, 0, 0, 0, 0, 0, 0};   sendAndCheck("ac1", v, 64'h1400001414000014, 8'h66);

    got = 0; first = -1; last = -1;
    for (int s = 0; s < 30; s++) begin
      if (out_valid) begin
        checkOutput("stream_x", x_out, splat(got));
        if (first < 0) first = s;
        last = s;
        got++;
      end
      if (s < 10) begin
        v = '{default: 0};
        v[0] = 8 * s;
        applyStimulus(1'b1, v, 1'b1, acc, rdy);
        checkOutput("stream_accept", 64'(acc), 64'd1);
      end else begin
        applyStimulus(1'b0, z, 1'b1, acc, rdy);
      end
    end
    checkOutput("stream_count", 64'(got), 64'd10);
    checkOutput("stream_rate", 64'(last - first), 64'd9);

    acv[0] = '{120, -35, 64, 7, -90, 18, -3, 250};
    acv[1] = '{-1000, 512, -300, 77, 33, -640, 250, -8};
    acv[2] = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
    acv[3] = '{1, -1, 3, -5, 11, 13, -17, 19};
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, acv[j], 1'b1, acc, rdy);
      checkOutput("ac_accept", 64'(acc), 64'd1);
    end
    repeat (12) applyStimulus(1'b0, z, 1'b1, acc, rdy);

    sent = 0; bp_got = 0; held = '0;
    for (int s = 0; s < 30; s++) begin
      ordy = !(s >= 10 && s <= 12);
      if (out_valid && ordy) bp_got++;
      if (s == 10) held = x_out;
      if (s >= 11 && s <= 13) begin
        checkOutput("bp_hold_x", x_out, held);
        checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      if (sent < 6 && (s < 3 || s >= 9)) begin
        v = '{160 + 80 * sent, 16 * sent, -8 * sent, 0, 24, 0, -40, 8 * sent};
        applyStimulus(1'b1, v, ordy, acc, rdy);
        if (acc) sent++;
      end else begin
        applyStimulus(1'b0, z, ordy, acc, rdy);
      end
      if (!ordy) checkOutput("bp_in_ready", 64'(rdy), 64'd0);
    end
    checkOutput("bp_sent", 64'(sent), 64'd6);
    checkOutput("bp_count", 64'(bp_got), 64'd6);

    for (int s = 0; s < 4; s++) begin
      v = '{default: 0};
      v[0] = 400 + 8 * s;
      v[3] = 50 - s;
      applyStimulus(1'b1, v, 1'b1, acc, rdy);
      checkOutput("rst_fill_accept", 64'(acc), 64'd1);
    end
    rst = 1'b1;
    applyStimulus(1'b0, v, 1'b1, acc, rdy);
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_x", x_out, 64'd0);
    checkOutput("rst_clip", 64'(out_clip), 64'd0);
    ghost = 0;
    for (int s = 0; s < 15; s++) begin
      if (out_valid) ghost++;
      applyStimulus(1'b0, z, 1'b1, acc, rdy);
    end
    checkOutput("rst_no_ghost", 64'(ghost), 64'd0);
    v = '{400, 0, 0, 0, 0, 0, 0, 0};
    sendAndCheck("post_rst", v, 64'h3232323232323232, 8'h00);

    repeat (12) applyStimulus(1'b0, z, 1'b1, acc, rdy);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/idct_ft_math.md
Name: idct_ft_math

Overview:
- Pipelined 8-point 1-D inverse DCT, the decode-side counterpart of the forward fixed-point lifting DCT.
- Undoes the forward butterfly and lifting chain in reverse order, in the same 3-fractional-bit shift-add arithmetic.
- Accepts one vector of 8 signed 16-bit coefficients per beat and emits 8 clamped unsigned W-bit pixels.
- Sits between dequantisation and the block-transpose buffer of the decoder; two instances, row and column, form the 2-D IDCT.

Parameters:
- W, 8, output pixel width in bits (unsigned).
- IW, 24, internal signed datapath width; must be at least 23.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  coefficient vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- y_in  in  16x8 (signed)  coefficients y[0..7].
- out_valid  out  1  pixel vector valid.
- out_ready  in  1  downstream accepts the vector this cycle.
- x_out  out  Wx8 (unsigned)  reconstructed pixels x[0..7].
- out_clip  out  8  per-sample flag: x[i] was saturated.

Behaviour:
- Reset: one clock, synchronous active-high; port names clk and rst.
- While rst=1 at a clk edge, the following are cleared and stay at 0 until rst falls:
  - all stage data registers;
  - the valid bits;
  - out_valid, x_out, out_clip.
- Reset mid-stream discards every in-flight vector. No output is produced for those vectors.
- Stall: advance = ~out_valid | out_ready. in_ready = advance. All pipeline registers and valid bits update only when advance=1.
  - This is a global stall; there is no skid buffer.
  - A transfer happens when valid and ready are both 1.
- Latency: a vector accepted at edge t appears with out_valid=1 after edge t+8 when no stall occurs. Throughput is 1 vector per cycle.
- Internal scale: v = sign-extend(y) << 3, with 3 fractional bits.
- R(v): rounds v to a multiple of 8, half away from zero.
  - Positive values: bit2=1 rounds up.
  - Negative values: increment only if bit2=1 and (bit1|bit0)=1.
  - Examples: R(4)=8, R(3)=0, R(12)=16, R(-4)=-8, R(-12)=-16.
- Stages (c = input vector, left-to-right within a stage):
  - S0: capture and scale.
  - S1: b1 = R(c0/2) - c1; b3 = c3 - R(c2*3/8); b4 = c4 + R(c7/8); b6 = c6 + R(c5/2); others pass through.
  - S2: b0 = c0 - b1; b2 = c2 + R(b3*3/8); b5 = c5 - R(b6*7/8); others pass through.
  - S3 (unnormalised butterflies):
    - a0 = b0 + b3; a3 = b0 - b3.
    - a1 = b1 + b2; a2 = b1 - b2.
    - a4 = b4 + b5; a5 = b4 - b5.
    - a7 = b7 + b6; a6 = b7 - b6.
  - S4: a5 = R(a6*5/8) - a5.
  - S5: a6 = a6 - R(a5*3/8).
  - S6: for i = 0..3: p[i] = a[i] + a[7-i]; p[7-i] = a[i] - a[7-i].
  - S7 output: q = p/32 rounded half away from zero. x = q clamped to 0..2^W-1. out_clip[i] = 1 iff clamping changed the value.
- Fractional products are formed by arithmetic right shifts summed before R, e.g. *3/8 = (v>>>3)+(v>>>2).
- All internal arithmetic is IW-bit signed; no overflow occurs for any 16-bit input when IW>=23.

Decomposition:
- Shared package dct_pkg holds:
  - the function R;
  - constant FRAC_BITS=3;
  - constant IDCT_OUT_SHIFT=5;
  - the pipeline depth constant IDCT_LAT=8;
  - typedef of the IW-bit signed vector-of-8.
- Sub-module idct_valid_pipe: the IDCT_LAT-deep valid shift register with the global stall enable.

Test Plan:
- DC: y = {800,0,0,0,0,0,0,0}, out_ready=1 -> out_valid exactly 8 cycles later; x all 100; out_clip=0.
- Negative clamp: y0=-80, rest 0 -> x all 0; out_clip=8'hFF. Overflow: y0=8000 -> x all 255; out_clip=8'hFF.
- Zeros: y all 0 -> x all 0. Streaming 10 consecutive DC vectors y0=8k, k=0..9 -> x=k in order, one vector per cycle.
- Backpressure: stream 6 vectors while out_ready is held low for 3 cycles mid-stream.
  - in_ready=0 while stalled.
  - Output data stays stable while stalled.
  - All 6 vectors arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 4 vectors in flight -> out_valid=0, x_out=0 next cycle; none of the 4 vectors ever emerges; a new vector afterwards has latency 8.
- Round-trip: random 8-bit vectors through the forward DCT then this block -> |x - original| <= 1 for all samples over 10k vectors.
